// File: rtl/comefa_ram_pkg.sv
// Shared types for the CoMeFa RAM streaming front-end.
// Holds the controller state encoding and the command direction codes.
package comefa_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_READ   = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    localparam logic DIR_WR = 1'b0;
    localparam logic DIR_RD = 1'b1;

endpackage

// File: rtl/ram_rd_fifo.sv
// Read-return FIFO that absorbs the RAM's registered read latency.
// Ports: clk_i/rst_ni, push_i/push_data_i, pop_i, head_o, count_o, empty_o.
module ram_rd_fifo #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [DWIDTH-1:0]      push_data_i,
    input  logic                   pop_i,
    output logic [DWIDTH-1:0]      head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is only legal when the head leaves this cycle.
    assign do_push = push_i && ((cnt_q != (PW+1)'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/ram_stream_ctrl.sv
// Streaming DMA front-end: turns write/read burst commands plus valid/ready
// word streams into RAM port A (write) and port B (read) traffic.
// Ports: cmd_* command handshake, in_* write stream, out_* read stream,
// done completion pulse, address_a/wren_a/data_a and address_b/wren_b/out_b
// toward the dual-port RAM.
module ram_stream_ctrl
    import comefa_ram_pkg::*;
#(
    parameter int AWIDTH    = 10,
    parameter int DWIDTH    = 32,
    parameter int RDQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [AWIDTH:0]   cmd_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              done,
    output logic [AWIDTH-1:0] address_a,
    output logic              wren_a,
    output logic [DWIDTH-1:0] data_a,
    output logic [AWIDTH-1:0] address_b,
    output logic              wren_b,
    input  logic [DWIDTH-1:0] out_b
);

    localparam int CW = $clog2(RDQ_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [AWIDTH:0]   remain_q, remain_d;
    logic              inflight_q, inflight_d;

    logic              wren_a_q;
    logic [AWIDTH-1:0] address_a_q;
    logic [DWIDTH-1:0] data_a_q;
    logic [AWIDTH-1:0] addr_b_q;

    logic              st_write, st_read;
    logic              have_left;
    logic              in_fire;
    logic              rd_issue;
    logic              rd_last;
    logic              out_fire;
    logic [CW-1:0]     fifo_cnt;
    logic              fifo_empty;
    logic [CW:0]       occ;

    assign st_write  = (state_q == ST_WRITE);
    assign st_read   = (state_q == ST_READ);
    assign have_left = (remain_q != '0);

    // Gating with resetn keeps cmd_ready low while reset is held.
    assign cmd_ready = resetn && (state_q == ST_IDLE);
    assign in_ready  = st_write && have_left;
    assign in_fire   = in_valid && in_ready;

    assign out_valid = st_read && !fifo_empty;
    assign out_fire  = out_valid && out_ready;

    // Words stored plus the one still coming back from the RAM must fit.
    assign occ      = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight_q};
    assign rd_issue = st_read && have_left
                   && (occ < (CW+1)'(RDQ_DEPTH));

    // Leave READ in the same cycle the final word is taken, so done
    // follows the last out handshake by exactly one cycle.
    assign rd_last = st_read && !have_left && !inflight_q
                  && (fifo_empty
                      || ((fifo_cnt == CW'(1)) && out_ready));

    assign done      = (state_q == ST_FINISH);
    assign wren_a    = wren_a_q;
    assign address_a = address_a_q;
    assign data_a    = data_a_q;
    assign wren_b    = 1'b0;
    // Port B address only moves when a read is actually issued.
    assign address_b = rd_issue ? cur_addr_q : addr_b_q;

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        remain_d   = remain_q;
        inflight_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cur_addr_d = cmd_addr;
                    remain_d   = cmd_len;
                    if (cmd_len == '0) begin
                        state_d = ST_FINISH;
                    end else if (cmd_dir == DIR_RD) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (in_fire) begin
                    cur_addr_d = cur_addr_q + AWIDTH'(1);
                    remain_d   = remain_q - (AWIDTH+1)'(1);
                end
                // One drain cycle lets the final port-A write go out
                // before done is raised.
                if (!have_left) state_d = ST_FINISH;
            end
            ST_READ: begin
                inflight_d = rd_issue;
                if (rd_issue) begin
                    cur_addr_d = cur_addr_q + AWIDTH'(1);
                    remain_d   = remain_q - (AWIDTH+1)'(1);
                end
                if (rd_last) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            remain_q   <= '0;
            inflight_q <= 1'b0;
            addr_b_q   <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            remain_q   <= remain_d;
            inflight_q <= inflight_d;
            addr_b_q   <= address_b;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wren_a_q    <= 1'b0;
            address_a_q <= '0;
            data_a_q    <= '0;
        end else begin
            wren_a_q <= in_fire;
            if (in_fire) begin
                address_a_q <= cur_addr_q;
                data_a_q    <= in_data;
            end
        end
    end

    ram_rd_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (RDQ_DEPTH)
    ) u_rd_fifo (
        .clk_i       (clk),
        .rst_ni      (resetn),
        .push_i      (inflight_q),
        .push_data_i (out_b),
        .pop_i       (out_fire),
        .head_o      (out_data),
        .count_o     (fifo_cnt),
        .empty_o     (fifo_empty)
    );

endmodule

// File: tb/tb_ram_stream_ctrl.sv
// Randomized bench for ram_stream_ctrl with a behavioural RAM and
// a queue-based reference model compared every cycle.
module tb_ram_stream_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_dir = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW:0]   cmd_len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          done;
    logic [AW-1:0] address_a;
    logic          wren_a;
    logic [DW-1:0] data_a;
    logic [AW-1:0] address_b;
    logic          wren_b;
    logic [DW-1:0] out_b;

    ram_stream_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .RDQ_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .done(done),
        .address_a(address_a), .wren_a(wren_a), .data_a(data_a),
        .address_b(address_b), .wren_b(wren_b), .out_b(out_b)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM with registered port-B read.
    logic [DW-1:0] ram [NW];
    always @(posedge clk) begin
        if (wren_a) ram[address_a] <= data_a;
        out_b <= ram[address_b];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int            due;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    // Reference model state.
    logic [DW-1:0] ref_mem [NW];
    wr_t           pend[$];
    logic [DW-1:0] exp_rd[$];
    logic [AW-1:0] got_wa[$];
    logic [DW-1:0] got_rd[$];
    bit            mon_en = 1'b0;
    bit            busy = 1'b0;
    bit            wr_act = 1'b0;
    bit            rd_act = 1'b0;
    bit            rd_strict = 1'b0;
    int            wr_left = 0;
    int            exp_done = -1;
    int            rd_acc = 0;
    int            rd_idx = 0;
    int            last_acc = 0;
    int            last_done = 0;
    int            rmode = 0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] ra;
    wr_t           wt;
    logic [DW-1:0] dt;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("wren_b", wren_b, 0);
            chk("cmd_ready", cmd_ready, !busy);
            chk("in_ready", in_ready, wr_left > 0);
            if (!rd_act) chk("out_valid_idle", out_valid, 0);

            if (pend.size() > 0 && pend[0].due == cyc) begin
                wt = pend.pop_front();
                chk("wren_a", wren_a, 1);
                chk("address_a", address_a, wt.a);
                chk("data_a", data_a, wt.d);
                got_wa.push_back(address_a);
                if (wr_act && wr_left == 0 && pend.size() == 0)
                    exp_done = cyc + 1;
            end else if (wren_a) begin
                chk("wren_a_spurious", wren_a, 0);
            end

            if (in_valid && in_ready) begin
                wt.due = cyc + 1;
                wt.a = wr_addr;
                wt.d = in_data;
                pend.push_back(wt);
                ref_mem[wr_addr] = in_data;
                wr_addr = wr_addr + 1'b1;
                wr_left--;
            end

            if (out_valid && out_ready) begin
                if (exp_rd.size() == 0) begin
                    chk("out_extra", out_valid, 0);
                end else begin
                    dt = exp_rd.pop_front();
                    chk("out_data", out_data, dt);
                    got_rd.push_back(out_data);
                    if (rd_strict)
                        chk("out_cycle", cyc, rd_acc + 3 + rd_idx);
                    rd_idx++;
                    if (exp_rd.size() == 0) exp_done = cyc + 1;
                end
            end

            if (done || cyc == exp_done) begin
                chk("done", done, cyc == exp_done);
                if (done) begin
                    busy = 0;
                    wr_act = 0;
                    rd_act = 0;
                    exp_done = -1;
                    last_done = cyc;
                end
            end

            if (cmd_valid && cmd_ready) begin
                busy = 1;
                last_acc = cyc;
                if (cmd_len == '0) begin
                    exp_done = cyc + 1;
                end else if (cmd_dir == 1'b0) begin
                    wr_act = 1;
                    wr_left = int'(cmd_len);
                    wr_addr = cmd_addr;
                end else begin
                    rd_act = 1;
                    rd_acc = cyc;
                    rd_idx = 0;
                    rd_strict = (rmode == 0);
                    ra = cmd_addr;
                    for (int i = 0; i < int'(cmd_len); i++) begin
                        exp_rd.push_back(ref_mem[ra]);
                        ra = ra + 1'b1;
                    end
                end
            end
        end
    end

    // Output backpressure: 0 steady, 1 random, 2 pattern 1-0-0-1, 3 stalled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                2: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'b0;
            endcase
        end
    end

    logic [DW-1:0] wdata[$];

    task automatic start_cmd(bit dir, int addr, int len);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_dir = dir;
        cmd_addr = AW'(addr);
        cmd_len = (AW+1)'(len);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) return;
        end
        chk("accept_timeout", cmd_ready, 1);
    endtask

    task automatic feed_write(int len, int gap);
        int k = 0;
        int t = 0;
        while (k < len && t < len * 20 + 100) begin
            @(posedge clk);
            #1;
            in_valid = ($urandom_range(0, 99) >= gap);
            in_data = (k < wdata.size()) ? wdata[k] : $urandom;
            @(negedge clk);
            if (in_valid && in_ready) k++;
            t++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (k != len) chk("write_timeout", k, len);
    endtask

    task automatic wait_done(int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
                return;
            end
        end
        chk("done_timeout", done, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic run(bit dir, int addr, int len, int gap);
        start_cmd(dir, addr, len);
        if (dir == 1'b0 && len > 0) feed_write(len, gap);
        wait_done(len * 10 + 100);
        wdata.delete();
    endtask

    task automatic clear_model();
        pend.delete();
        exp_rd.delete();
        busy = 0;
        wr_act = 0;
        rd_act = 0;
        wr_left = 0;
        exp_done = -1;
    endtask

    logic [AW-1:0] ab;
    int            ln;

    initial begin
        #2;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_wren_a", wren_a, 0);
        chk("rst_wren_b", wren_b, 0);
        chk("rst_address_a", address_a, 0);
        chk("rst_address_b", address_b, 0);
        chk("rst_data_a", data_a, 0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        chk("cmd_ready_after_rst", cmd_ready, 1);
        mon_en = 1'b1;

        // Full-RAM write burst initialises every location.
        rmode = 0;
        run(1'b0, 0, NW, 20);

        // Directed write with literal expectations.
        got_wa.delete();
        wdata = '{32'hA0, 32'hA1, 32'hA2};
        run(1'b0, 'h010, 3, 0);
        chk("wr_n", got_wa.size(), 3);
        if (got_wa.size() == 3) begin
            chk("wr_a0", got_wa[0], 'h010);
            chk("wr_a1", got_wa[1], 'h011);
            chk("wr_a2", got_wa[2], 'h012);
        end
        chk("wr_done_lat", last_done - last_acc, 5);

        // Directed read, steady out_ready.
        got_rd.delete();
        run(1'b1, 'h010, 3, 0);
        chk("rd_n", got_rd.size(), 3);
        if (got_rd.size() == 3) begin
            chk("rd_d0", got_rd[0], 32'hA0);
            chk("rd_d1", got_rd[1], 32'hA1);
            chk("rd_d2", got_rd[2], 32'hA2);
        end
        chk("rd_done_lat", last_done - last_acc, 6);

        // Read with 1-0-0-1 backpressure.
        rmode = 2;
        got_rd.delete();
        run(1'b1, 'h010, 8, 0);
        chk("bp_n", got_rd.size(), 8);
        if (got_rd.size() == 8) chk("bp_d2", got_rd[2], 32'hA2);

        // Address wrap on write.
        rmode = 0;
        got_wa.delete();
        run(1'b0, 'h3FE, 4, 30);
        chk("wrap_n", got_wa.size(), 4);
        if (got_wa.size() == 4) begin
            chk("wrap_a0", got_wa[0], 'h3FE);
            chk("wrap_a1", got_wa[1], 'h3FF);
            chk("wrap_a2", got_wa[2], 'h000);
            chk("wrap_a3", got_wa[3], 'h001);
        end

        // Full-RAM read with random backpressure.
        rmode = 1;
        got_rd.delete();
        run(1'b1, 'h200, NW, 0);
        chk("full_rd_n", got_rd.size(), NW);

        // Zero-length commands.
        rmode = 0;
        ab = address_b;
        run(1'b1, 'h155, 0, 0);
        chk("zero_rd_lat", last_done - last_acc, 1);
        chk("zero_rd_addr_b", address_b, ab);
        run(1'b0, 'h2AA, 0, 0);
        chk("zero_wr_lat", last_done - last_acc, 1);

        // Random command mix.
        for (int n = 0; n < 25; n++) begin
            rmode = $urandom_range(0, 2);
            ln = $urandom_range(1, 40);
            if ($urandom_range(0, 7) == 0) ln = 0;
            if ($urandom_range(0, 9) == 0) ln = $urandom_range(100, 300);
            run(1'($urandom_range(0, 1)), $urandom_range(0, NW - 1),
                ln, $urandom_range(0, 60));
        end

        // Reset in the middle of a stalled read.
        rmode = 3;
        start_cmd(1'b1, 'h010, 8);
        repeat (4) @(posedge clk);
        #2;
        chk("pre_rst_out_valid", out_valid, 1);
        mon_en = 1'b0;
        resetn = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_wren_a", wren_a, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        cmd_valid = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);
        rmode = 0;
        mon_en = 1'b1;
        run(1'b0, 'h020, 5, 0);
        got_rd.delete();
        run(1'b1, 'h020, 5, 0);
        chk("post_rst_rd_n", got_rd.size(), 5);

        repeat (3) @(posedge clk);
        chk("left_rd", exp_rd.size(), 0);
        chk("left_wr", pend.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_stream_ctrl.md
# ram_stream_ctrl

Streaming DMA front-end for the CoMeFa dual-port RAM wrapper, sitting directly upstream of it. Accepts one command at a time (write-burst or read-burst) and converts valid/ready word streams into RAM port traffic. Writes use RAM port A; reads use RAM port B. The RAM's 1-cycle registered read latency is absorbed by an internal read FIFO, so the output stream tolerates arbitrary backpressure.

## Interface
- AWIDTH, 10, RAM address width; RAM depth is 2^AWIDTH words.
- DWIDTH, 32, word width.
- RDQ_DEPTH, 4, read FIFO entries; power of two, ≥ 4.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- cmd_dir  in  1  0 = write burst into RAM, 1 = read burst from RAM.
- cmd_addr  in  AWIDTH  start address.
- cmd_len  in  AWIDTH+1  word count, 0..2^AWIDTH.
- in_valid / in_ready  in / out  1  write-data handshake.
- in_data  in  DWIDTH  write data.
- out_valid / out_ready  out / in  1  read-data handshake.
- out_data  out  DWIDTH  read data.
- done  out  1  one-cycle pulse at command completion.
- address_a, wren_a, data_a  out  AWIDTH, 1, DWIDTH  RAM port A.
- address_b, wren_b  out  AWIDTH, 1  RAM port B; wren_b is constant 0.
- out_b  in  DWIDTH  RAM port B read data, valid one cycle after address_b.

## Operation
- States: IDLE, WRITE, READ, FINISH.
- IDLE:
  - cmd_ready=1.
  - On handshake: latch addr/len/dir.
  - len=0 → FINISH.
  - Otherwise dir=0 → WRITE, dir=1 → READ.
- WRITE:
  - in_ready=1.
  - Each in handshake registers address_a=cur_addr, data_a=in_data, wren_a=1 for exactly the next cycle.
  - cur_addr increments; remaining decrements.
  - After the last handshake → FINISH.
- READ:
  - Issue a read (address_b=cur_addr) whenever remaining>0 and fifo_count+inflight < RDQ_DEPTH.
  - The issued word is pushed into the FIFO from out_b on the following cycle.
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - Once all words are issued, the inflight read has landed, and the FIFO has drained → FINISH.
- FINISH: done=1 for one cycle → IDLE.
- Addresses wrap modulo 2^AWIDTH. Example: start 0x3FE, len 4 → 0x3FE, 0x3FF, 0x000, 0x001.
- cmd_len is interpreted unsigned; max 2^AWIDTH (full-RAM burst).
- While not in WRITE: in_ready=0. out_valid is 0 outside READ, except FIFO content cannot exist outside READ.
- Port A and port B are never active in the same command, so there is no same-address collision.

## Timing
- Reset values: cmd_ready=0 during reset, 1 in the first cycle after release. in_ready=0, out_valid=0, done=0, wren_a=0, wren_b=0, address_a=0, address_b=0, data_a=0, out_data=don't-care.
- Reset mid-operation: FSM → IDLE, FIFO emptied, inflight cleared, wren_a deasserted immediately (asynchronous).
- Command accept at cycle t → WRITE/READ active at t+1.
- Write: in handshake at t → RAM write at the edge ending t+1. Full throughput: one word per cycle.
- Read: issue at t → out_b valid at t+1 → FIFO push at end of t+1 → out_valid at t+2 (2-cycle latency).
- Read throughput is one word per cycle with out_ready held high.
- done asserts one cycle after:
  - write: the cycle the last wren_a is presented;
  - read: the last out handshake;
  - len=0: the accept.
- cmd_ready=0 from accept through the done cycle; the next command can be accepted the cycle after done.

## Structure
- Package comefa_ram_pkg holds:
  - the state enum (IDLE/WRITE/READ/FINISH);
  - the cmd_dir encodings (DIR_WR=0, DIR_RD=1).
- Sub-module ram_rd_fifo: synchronous FIFO, DWIDTH × RDQ_DEPTH, with count output, async active-low reset.
- Top level holds the FSM, address/length counters, the inflight flag, and the port-A output registers.

## Test plan
- Write burst: addr 0x010, len 3, data A0,A1,A2 back-to-back → wren_a at 0x010/0x011/0x012 on consecutive cycles; single done pulse one cycle after the last write.
- Read burst, out_ready=1: after the write above, read addr 0x010, len 3 → out_data A0,A1,A2 on three consecutive cycles starting 2 cycles after the first issue; done after A2.
- Read with backpressure: len 8, out_ready toggling 1-0-0-1 → all 8 words delivered in order; no loss or duplication; FIFO never exceeds RDQ_DEPTH.
- Wrap and full burst:
  - write addr 0x3FE, len 4 → addresses 0x3FE, 0x3FF, 0x000, 0x001;
  - len 1024 read completes with exactly 1024 out handshakes.
- Zero length and busy: len 0 → done exactly 1 cycle after accept with no wren_a or address_b activity; cmd_valid held during busy → cmd_ready stays 0 until the cycle after done.
- Reset mid-read: drop resetn with 2 words in the FIFO → out_valid, wren_a, done go 0 asynchronously; after release cmd_ready=1 and a new command runs normally.
